// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 timing constants, pixel-coordinate type and a window-decode helper
package vga_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef logic [9:0] coord_t;

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return v >= lo && v < hi;
    endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// vga_scan_gen_if: VGA scan outputs toward the colour mapper; frame_cnt exists only with VGA_FRAME_COUNT_EN
interface vga_scan_gen_if;
    import vga_pkg::*;

    logic   VGA_CLK;
    logic   VGA_HS;
    logic   VGA_VS;
    logic   VGA_BLANK_N;
    coord_t DrawX;
    coord_t DrawY;
    logic   frame_start;
    logic   line_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt;

    modport master (output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, DrawX, DrawY,
                    frame_start, line_start, frame_cnt);
    modport slave  (input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, DrawX, DrawY,
                    frame_start, line_start, frame_cnt);
`else
    modport master (output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, DrawX, DrawY,
                    frame_start, line_start);
    modport slave  (input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, DrawX, DrawY,
                    frame_start, line_start);
`endif

endinterface

// File: rtl/vga_mod_counter.sv
// vga_mod_counter: modulo-N counter with enable, synchronous active-low clear and terminal-count flag
module vga_mod_counter #(
    parameter int N = 800,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    // Advance when enabled, folding back to zero after the last state
    always_ff @(posedge clk)
        count <= !clr_n ? '0 : en ? (tc ? '0 : count + 1'b1) : count;

    assign tc = count == LAST;

endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster scan generator (pixel clock, sync, blanking, coordinates); optional frame_cnt via VGA_FRAME_COUNT_EN
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic           Clk,
    input  logic           Reset,
    vga_scan_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_VIS = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS = coord_t'(V_VISIBLE);
    localparam coord_t HS_LO = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_HI = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_LO = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_HI = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    logic   pix_en;
    coord_t hc;
    coord_t vc;
    logic   hc_tc;
    logic   vc_tc;
    logic   line_end;

    // Pixel enable runs at half the system clock and doubles as VGA_CLK
    always_ff @(posedge Clk)
        pix_en <= Reset ? ~pix_en : 1'b0;

    assign line_end = pix_en & hc_tc;

    vga_mod_counter #(.N(H_TOTAL), .W(10)) u_hc (
        .clk   (Clk),
        .clr_n (Reset),
        .en    (pix_en),
        .count (hc),
        .tc    (hc_tc)
    );

    vga_mod_counter #(.N(V_TOTAL), .W(10)) u_vc (
        .clk   (Clk),
        .clr_n (Reset),
        .en    (line_end),
        .count (vc),
        .tc    (vc_tc)
    );

    // Decode sync and blanking straight from the counter registers so they line up with DrawX/DrawY
    always_comb begin
        vga.VGA_CLK     = pix_en;
        vga.DrawX       = hc;
        vga.DrawY       = vc;
        vga.VGA_HS      = ~in_window(hc, HS_LO, HS_HI);
        vga.VGA_VS      = ~in_window(vc, VS_LO, VS_HI);
        vga.VGA_BLANK_N = hc < H_VIS && vc < V_VIS;
        vga.line_start  = line_end;
        vga.frame_start = line_end & vc_tc;
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q;

    // Count completed frames, rolling over naturally at 16 bits
    always_ff @(posedge Clk)
        frame_cnt_q <= !Reset ? '0 : (line_end & vc_tc) ? frame_cnt_q + 1'b1 : frame_cnt_q;

    assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: checks a default-timing and a miniature-timing scan generator against an arithmetic raster model
module tb_vga_scan_gen;

    typedef struct packed {
        logic       clk;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct {
        int   n;
        obs_t exp;
    } vec_t;

    localparam int BHV = 8, BHF = 2, BHS = 3, BHB = 2;
    localparam int BVV = 6, BVF = 1, BVS = 2, BVB = 2;
    localparam int BFRAME = (BHV + BHF + BHS + BHB) * (BVV + BVF + BVS + BVB) * 2;

    logic Clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   na, nb;
    int   n_chk = 0;
    int   n_fail = 0;
    int   hs_low = 0;
    vec_t tbl[$];
    obs_t got_a, got_b;

    always #10 Clk = ~Clk;

    vga_scan_gen_if ia();
    vga_scan_gen_if ib();

    vga_scan_gen u_a (
        .Clk   (Clk),
        .Reset (rst_a),
        .vga   (ia.master)
    );

    vga_scan_gen #(
        .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
    ) u_b (
        .Clk   (Clk),
        .Reset (rst_b),
        .vga   (ib.master)
    );

    assign got_a = {ia.VGA_CLK, ia.DrawX, ia.DrawY, ia.VGA_HS, ia.VGA_VS, ia.VGA_BLANK_N, ia.line_start, ia.frame_start};
    assign got_b = {ib.VGA_CLK, ib.DrawX, ib.DrawY, ib.VGA_HS, ib.VGA_VS, ib.VGA_BLANK_N, ib.line_start, ib.frame_start};

    // n = Clk edges since the reset edge; each pixel spans two edges
    function automatic obs_t model(int n, int hv, int hf, int hsw, int hb, int vv, int vf, int vsw, int vb);
        obs_t m;
        int ht = hv + hf + hsw + hb;
        int vt = vv + vf + vsw + vb;
        int p = n / 2;
        int x = p % ht;
        int y = (p / ht) % vt;
        m.clk = (n % 2) == 1;
        m.x   = 10'(x);
        m.y   = 10'(y);
        m.hs  = !(x >= hv + hf && x < hv + hf + hsw);
        m.vs  = !(y >= vv + vf && y < vv + vf + vsw);
        m.bl  = x < hv && y < vv;
        m.ls  = m.clk && x == ht - 1;
        m.fs  = m.ls && y == vt - 1;
        return m;
    endfunction

    function automatic obs_t mk(bit c, int x, int y, bit hs, bit vs, bit bl, bit ls, bit fs);
        obs_t m;
        m.clk = c; m.x = 10'(x); m.y = 10'(y);
        m.hs = hs; m.vs = vs; m.bl = bl; m.ls = ls; m.fs = fs;
        return m;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("clk=%0b x=%0d y=%0d hs=%0b vs=%0b bl=%0b ls=%0b fs=%0b",
                         o.clk, o.x, o.y, o.hs, o.vs, o.bl, o.ls, o.fs);
    endfunction

    task automatic chk(string name, int n, obs_t got, obs_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s n=%0d got {%s} expected {%s}", name, n, fmt(got), fmt(exp));
        end
    endtask

    task automatic chk_int(string name, int got, int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_models();
        chk("scan_a", na, got_a, model(na, 640, 16, 96, 48, 480, 10, 2, 33));
        chk("scan_b", nb, got_b, model(nb, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB));
        foreach (tbl[i])
            if (tbl[i].n == na && rst_a)
                chk("vec_a", na, got_a, tbl[i].exp);
    endtask

    task automatic step();
        @(posedge Clk);
        na = rst_a ? na + 1 : 0;
        nb = rst_b ? nb + 1 : 0;
        @(negedge Clk);
        check_models();
    endtask

    initial begin
        int found;
        int bl_cnt, vs_cnt, ls_cnt, fs_cnt;
        rst_a = 1'b0;
        rst_b = 1'b0;
        tbl.push_back('{0,    mk(0, 0,   0, 1, 1, 1, 0, 0)});
        tbl.push_back('{1,    mk(1, 0,   0, 1, 1, 1, 0, 0)});
        tbl.push_back('{2,    mk(0, 1,   0, 1, 1, 1, 0, 0)});
        tbl.push_back('{1279, mk(1, 639, 0, 1, 1, 1, 0, 0)});
        tbl.push_back('{1280, mk(0, 640, 0, 1, 1, 0, 0, 0)});
        tbl.push_back('{1312, mk(0, 656, 0, 0, 1, 0, 0, 0)});
        tbl.push_back('{1503, mk(1, 751, 0, 0, 1, 0, 0, 0)});
        tbl.push_back('{1504, mk(0, 752, 0, 1, 1, 0, 0, 0)});
        tbl.push_back('{1599, mk(1, 799, 0, 1, 1, 0, 1, 0)});
        tbl.push_back('{1600, mk(0, 0,   1, 1, 1, 1, 0, 0)});
        repeat (3) @(posedge Clk);
        na = 0;
        nb = 0;
        @(negedge Clk);
        chk("reset_a", 0, got_a, mk(0, 0, 0, 1, 1, 1, 0, 0));
        check_models();
`ifdef VGA_FRAME_COUNT_EN
        chk_int("frame_cnt_reset", int'(ia.frame_cnt), 0);
`endif
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int c = 1; c <= 3400; c++) begin
            step();
            if (na < 1600 && !ia.VGA_HS)
                hs_low++;
            rst_b = $urandom_range(0, 799) != 0;
        end
        chk_int("hs_low_cycles_a", hs_low, 192);

        rst_b = 1'b1;
        found = 0;
        for (int c = 0; c < 1000 && !found; c++) begin
            step();
            if (ib.DrawX == 10'd11 && ib.DrawY == 10'd8)
                found = 1;
        end
        chk_int("reach_sync_b", found, 1);
        if (found) begin
            chk_int("hs_vs_low_b", {ib.VGA_HS, ib.VGA_VS}, 0);
            rst_b = 1'b0;
            step();
            chk("reset_mid_frame_b", nb, got_b, mk(0, 0, 0, 1, 1, 1, 0, 0));
            rst_b = 1'b1;
            step();
            step();
            chk_int("first_advance_b", int'(ib.DrawX), 1);
        end

        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        bl_cnt = 0; vs_cnt = 0; ls_cnt = 0; fs_cnt = 0;
        for (int c = 0; c < BFRAME; c++) begin
            if (c > 0)
                step();
            if (ib.VGA_BLANK_N && ib.VGA_CLK) bl_cnt++;
            if (!ib.VGA_VS) vs_cnt++;
            if (ib.line_start) ls_cnt++;
            if (ib.frame_start) fs_cnt++;
            if (c == BFRAME - 1)
                chk_int("last_pixel_pulses_b", {ib.frame_start, ib.line_start}, 3);
        end
        chk_int("visible_pixels_b", bl_cnt, BHV * BVV);
        chk_int("vs_low_cycles_b", vs_cnt, BVS * (BHV + BHF + BHS + BHB) * 2);
        chk_int("line_pulses_b", ls_cnt, BVV + BVF + BVS + BVB);
        chk_int("frame_pulses_b", fs_cnt, 1);
        step();
        chk_int("wrap_xy_b", {22'd0, ib.DrawX, ib.DrawY}, 0);
`ifdef VGA_FRAME_COUNT_EN
        chk_int("frame_cnt_b", int'(ib.frame_cnt), 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
